// File: rtl/serial_fcs_inserter_if.sv
// serial_fcs_inserter_if
//   Bit-serial stream bundle between the TX frame serializer, the FCS
//   inserter and the line driver.
//
//   in_valid / in_ready : upstream handshake, a bit moves when both are high
//   in_data             : serial bit in transmission order
//   in_sof / in_eof     : first preamble bit / last payload bit markers
//   out_valid           : out_data carries a line bit this cycle
//   out_data            : serial bit to the line
//   out_sof / out_eof   : first bit of frame / last FCS bit markers
//
//   modport master : the side that sources in_* and sinks out_*
//   modport slave  : the FCS inserter itself
interface serial_fcs_inserter_if;
  logic in_valid;
  logic in_ready;
  logic in_data;
  logic in_sof;
  logic in_eof;
  logic out_valid;
  logic out_data;
  logic out_sof;
  logic out_eof;

  modport master (
    output in_valid,
    output in_data,
    output in_sof,
    output in_eof,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sof,
    input  out_eof
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sof,
    input  in_eof,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sof,
    output out_eof
  );
endinterface

// File: rtl/serial_fcs_inserter.sv
// serial_fcs_inserter
//   Bit-serial Ethernet transmit FCS generator. Preamble/SFD bits after
//   in_sof are forwarded untouched; every later bit is forwarded and run
//   through CRC-32 (poly 04C11DB7, init all-ones, MSB-first shift). After the
//   in_eof bit the complemented CRC is shifted out MSB-first, which puts the
//   reflected Ethernet FCS on the wire LSB-first. in_ready is dropped while
//   the block generates bits on its own.
//
//   Optional feature, macro SERIAL_FCS_PAD_EN: short payloads are padded with
//   zero bits (included in the CRC) up to MIN_PAYLOAD_BITS before the FCS.
//
// Ports
//   clk        : clock
//   reset      : asynchronous active-low reset
//   bus        : serial_fcs_inserter_if.slave (in_* handshake, out_* stream)
//   busy       : state is not IDLE
//   abort      : one-cycle pulse, in_eof accepted during the preamble
//   fcs_value  : FCS of the last completed frame
module serial_fcs_inserter #(
  parameter int unsigned PREAMBLE_BITS    = 64,
  parameter int unsigned MIN_PAYLOAD_BITS = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_fcs_inserter_if.slave bus,
  output logic                 busy,
  output logic                 abort,
  output logic [31:0]          fcs_value
);

  // Both lengths are compared against the 16-bit bit counter.
  if (PREAMBLE_BITS < 1 || PREAMBLE_BITS > 65535 ||
      MIN_PAYLOAD_BITS > 65535) begin : g_param_range_error
    $error("serial_fcs_inserter: PREAMBLE_BITS/MIN_PAYLOAD_BITS out of range");
  end

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [15:0] PRE_LEN  = 16'(PREAMBLE_BITS);
`ifdef SERIAL_FCS_PAD_EN
  localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD_BITS);
`endif

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
`ifdef SERIAL_FCS_PAD_EN
    ST_PAD      = 3'd3,
`endif
    ST_FCS      = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] bit_c_q, bit_c_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs_q, fcs_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        out_data_q, out_data_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;
  logic        abort_q, abort_d;

  logic        accept;
  logic [15:0] bit_c_inc;

  function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                           input logic        d);
    logic fb;
    fb = d ^ crc[31];
    return {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
  endfunction

  assign accept    = bus.in_valid && in_ready_q;
  // Saturating so an over-long frame cannot wrap into a "short" count.
  assign bit_c_inc = (bit_c_q == '1) ? bit_c_q : bit_c_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    bit_c_d     = bit_c_q;
    crc_d       = crc_q;
    fcs_d       = fcs_q;
    out_valid_d = 1'b0;
    out_data_d  = 1'b0;
    out_sof_d   = 1'b0;
    out_eof_d   = 1'b0;
    abort_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Bits arriving without in_sof are swallowed here.
        if (accept && bus.in_sof) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.in_data;
          out_sof_d   = 1'b1;
          crc_d       = '1;
          if (bus.in_eof) begin
            abort_d = 1'b1;
            bit_c_d = '0;
          end else if (PRE_LEN == 16'd1) begin
            state_d = ST_DATA;
            bit_c_d = '0;
          end else begin
            state_d = ST_PREAMBLE;
            bit_c_d = 16'd1;
          end
        end
      end

      ST_PREAMBLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.in_data;
          if (bus.in_eof) begin
            abort_d = 1'b1;
            state_d = ST_IDLE;
            bit_c_d = '0;
          end else if (bit_c_inc == PRE_LEN) begin
            state_d = ST_DATA;
            bit_c_d = '0;
          end else begin
            bit_c_d = bit_c_inc;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.in_data;
          crc_d       = crc_step(crc_q, bus.in_data);
          bit_c_d     = bit_c_inc;
          if (bus.in_eof) begin
`ifdef SERIAL_FCS_PAD_EN
            if (bit_c_inc < MIN_LEN) begin
              state_d = ST_PAD;
            end else begin
              state_d = ST_FCS;
              bit_c_d = '0;
              fcs_d   = ~crc_d;
            end
`else
            state_d = ST_FCS;
            bit_c_d = '0;
            fcs_d   = ~crc_d;
`endif
          end
        end
      end

`ifdef SERIAL_FCS_PAD_EN
      ST_PAD: begin
        out_valid_d = 1'b1;
        out_data_d  = 1'b0;
        crc_d       = crc_step(crc_q, 1'b0);
        bit_c_d     = bit_c_inc;
        if (bit_c_inc >= MIN_LEN) begin
          state_d = ST_FCS;
          bit_c_d = '0;
          fcs_d   = ~crc_d;
        end
      end
`endif

      ST_FCS: begin
        // Shifting the register out MSB-first emits the reflected FCS LSB-first.
        out_valid_d = 1'b1;
        out_data_d  = ~crc_q[31];
        crc_d       = {crc_q[30:0], 1'b0};
        bit_c_d     = bit_c_q + 16'd1;
        if (bit_c_q == 16'd31) begin
          out_eof_d = 1'b1;
          state_d   = ST_IDLE;
          bit_c_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        bit_c_d = '0;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_PREAMBLE) ||
                 (state_d == ST_DATA);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bit_c_q     <= '0;
      crc_q       <= '1;
      fcs_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_c_q     <= bit_c_d;
      crc_q       <= crc_d;
      fcs_q       <= fcs_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
  assign busy          = (state_q != ST_IDLE);
  assign abort         = abort_q;
  assign fcs_value     = fcs_q;

endmodule

// File: tb/tb_serial_fcs_inserter.sv
// tb_serial_fcs_inserter
//   Directed bench for serial_fcs_inserter: reset values, the "123456789"
//   reference frame, preamble abort, input gaps, back-to-back frames,
//   residue over random payloads, reset during the FCS and (with
//   SERIAL_FCS_PAD_EN) payload padding.
module tb_serial_fcs_inserter;
  logic        clk;
  logic        reset;
  logic        busy;
  logic        abort;
  logic [31:0] fcs_value;

  int checks;
  int failures;

  serial_fcs_inserter_if sif ();

  serial_fcs_inserter #(
    .PREAMBLE_BITS   (64),
    .MIN_PAYLOAD_BITS(480)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (sif),
    .busy     (busy),
    .abort    (abort),
    .fcs_value(fcs_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Output capture, sampled 1 time unit after each rising edge.
  logic obits[$];
  int   sof_cnt, eof_cnt, abort_cnt, gap_cnt, sof_idx, eof_idx;
  bit   in_frame;

  always @(posedge clk) begin
    #1;
    if (sif.out_valid) begin
      if (sif.out_sof) begin
        sof_cnt++;
        sof_idx  = obits.size();
        in_frame = 1'b1;
      end
      if (sif.out_eof) begin
        eof_cnt++;
        eof_idx  = obits.size();
        in_frame = 1'b0;
      end
      obits.push_back(sif.out_data);
    end else if (in_frame) begin
      gap_cnt++;
    end
    if (abort) abort_cnt++;
  end

  logic pre_bits[$];
  logic pay_basic[$];
  logic fcs_basic[$];
  logic exp_basic[$];

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic d);
    return {c[30:0], 1'b0} ^ ((d ^ c[31]) ? 32'h04C11DB7 : 32'h0);
  endfunction

  task automatic bytes_to_bits(input logic [7:0] bytes[$], output logic bits[$]);
    bits.delete();
    foreach (bytes[i]) begin
      for (int b = 0; b < 8; b++) bits.push_back(bytes[i][b]);
    end
  endtask

  task automatic clear_capture();
    obits.delete();
    sof_cnt   = 0;
    eof_cnt   = 0;
    abort_cnt = 0;
    gap_cnt   = 0;
    sof_idx   = 0;
    eof_idx   = 0;
    in_frame  = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_bit(input logic d, input logic s, input logic e,
                          output int tries);
    bit acc;
    acc   = 1'b0;
    tries = 0;
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    sif.in_sof   = s;
    sif.in_eof   = e;
    while (!acc && tries < 1000) begin
      acc = sif.in_ready;
      tries++;
      @(negedge clk);
    end
    sif.in_valid = 1'b0;
    sif.in_sof   = 1'b0;
    sif.in_eof   = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_bit_timeout in_ready stayed 0 for %0d cycles (required acceptance)", tries);
    end
  endtask

  task automatic idle_cycle();
    sif.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic pay[$], input int gap_every,
                            output int gaps, output int sof_tries);
    int t;
    gaps      = 0;
    sof_tries = 0;
    for (int i = 0; i < 64; i++) begin
      send_bit(pre_bits[i], logic'(i == 0), 1'b0, t);
      if (i == 0) sof_tries = t;
    end
    for (int i = 0; i < pay.size(); i++) begin
      if (gap_every != 0 && (i % gap_every) == 2) begin
        idle_cycle();
        gaps++;
      end
      send_bit(pay[i], 1'b0, logic'(i == pay.size() - 1), t);
    end
  endtask

  // Waits (bounded) for eof_cnt to reach target; counts in_ready highs seen.
  task automatic wait_eof(input int target, output int cycles, output int ready_hi);
    cycles   = 0;
    ready_hi = 0;
    while (eof_cnt < target && cycles < 2000) begin
      if (sif.in_ready) ready_hi++;
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", sif.out_valid); end
    checks++;
    if (sif.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", sif.in_ready); end
    checks++;
    if ({busy, abort, sif.out_sof, sif.out_eof, sif.out_data} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {busy, abort, sif.out_sof, sif.out_eof, sif.out_data});
    end
    checks++;
    if (fcs_value !== 32'h0) begin failures++; $display("FAIL reset_fcs_value got=%h exp=00000000", fcs_value); end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sif.in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", sif.in_ready); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int gaps, tries, cycles, ready_hi, bad, first;
    clear_capture();
    send_frame(pay_basic, 0, gaps, tries);
    wait_eof(1, cycles, ready_hi);
    checks++;
    if (cycles != 32) begin failures++; $display("FAIL basic_fcs_cycles got=%0d exp=32", cycles); end
    checks++;
    if (ready_hi != 0) begin failures++; $display("FAIL basic_ready_in_fcs got=%0d exp=0", ready_hi); end
    checks++;
    if (obits.size() != 168) begin failures++; $display("FAIL basic_length got=%0d exp=168", obits.size()); end
    bad = 0; first = 0;
    for (int i = 0; i < 168 && i < obits.size(); i++) begin
      if (obits[i] !== exp_basic[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL basic_stream bad_bits=%0d first_at=%0d exp_bad=0", bad, first); end
    checks++;
    if (fcs_value !== 32'h649C2FD3) begin failures++; $display("FAIL basic_fcs_value got=%h exp=649c2fd3", fcs_value); end
    checks++;
    if (sof_cnt != 1 || sof_idx != 0) begin failures++; $display("FAIL basic_sof count=%0d idx=%0d exp=1,0", sof_cnt, sof_idx); end
    checks++;
    if (eof_cnt != 1 || eof_idx != 167) begin failures++; $display("FAIL basic_eof count=%0d idx=%0d exp=1,167", eof_cnt, eof_idx); end
    checks++;
    if (gap_cnt != 0) begin failures++; $display("FAIL basic_gaps got=%0d exp=0", gap_cnt); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_abort();
    int t;
    clear_capture();
    for (int i = 0; i < 20; i++) send_bit(pre_bits[i], logic'(i == 0), logic'(i == 19), t);
    repeat (3) @(negedge clk);
    checks++;
    if (abort_cnt != 1) begin failures++; $display("FAIL abort_pulse got=%0d exp=1", abort_cnt); end
    checks++;
    if (obits.size() != 20) begin failures++; $display("FAIL abort_bits got=%0d exp=20", obits.size()); end
    checks++;
    if (eof_cnt != 0) begin failures++; $display("FAIL abort_no_fcs eof_count=%0d exp=0", eof_cnt); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++;
    if (fcs_value !== 32'h649C2FD3) begin failures++; $display("FAIL abort_fcs_kept got=%h exp=649c2fd3", fcs_value); end
  endtask

  task automatic test_gaps();
    int gaps, tries, cycles, ready_hi, bad;
    clear_capture();
    send_frame(pay_basic, 5, gaps, tries);
    wait_eof(1, cycles, ready_hi);
    checks++;
    if (ready_hi != 0 || cycles != 32) begin
      failures++;
      $display("FAIL gaps_fcs_stall ready_hi=%0d cycles=%0d exp=0,32", ready_hi, cycles);
    end
    bad = 0;
    for (int i = 0; i < 168; i++) begin
      if (i >= obits.size() || obits[i] !== exp_basic[i]) bad++;
    end
    checks++;
    if (bad != 0 || obits.size() != 168) begin
      failures++;
      $display("FAIL gaps_stream bad_bits=%0d length=%0d exp=0,168", bad, obits.size());
    end
    checks++;
    if (gap_cnt != gaps) begin failures++; $display("FAIL gaps_mirror got=%0d exp=%0d", gap_cnt, gaps); end
    checks++;
    if (fcs_value !== 32'h649C2FD3) begin failures++; $display("FAIL gaps_fcs_value got=%h exp=649c2fd3", fcs_value); end
  endtask

  task automatic test_back_to_back();
    int gaps, tries, cycles, ready_hi, bad;
    clear_capture();
    send_frame(pay_basic, 0, gaps, tries);
    wait_eof(1, cycles, ready_hi);
    send_frame(pay_basic, 0, gaps, tries);
    checks++;
    if (tries != 1) begin failures++; $display("FAIL b2b_sof_accept tries=%0d exp=1", tries); end
    wait_eof(2, cycles, ready_hi);
    checks++;
    if (obits.size() != 336 || sof_idx != 168) begin
      failures++;
      $display("FAIL b2b_layout length=%0d sof_idx=%0d exp=336,168", obits.size(), sof_idx);
    end
    bad = 0;
    for (int i = 0; i < 168; i++) begin
      if (168 + i >= obits.size() || obits[168 + i] !== exp_basic[i]) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL b2b_second_frame bad_bits=%0d exp=0", bad); end
  endtask

  task automatic test_residue();
    logic [7:0]  bytes[$];
    logic        pay[$];
    logic [31:0] r;
    int          n, gaps, tries, cycles, ready_hi;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(8, 40);
      bytes.delete();
      for (int k = 0; k < n; k++) bytes.push_back(8'($urandom));
      bytes_to_bits(bytes, pay);
      clear_capture();
      send_frame(pay, (f % 2 == 1) ? 7 : 0, gaps, tries);
      wait_eof(1, cycles, ready_hi);
      checks++;
      if (obits.size() != 64 + 8 * n + 32) begin
        failures++;
        $display("FAIL residue_length frame=%0d got=%0d exp=%0d", f, obits.size(), 64 + 8 * n + 32);
      end
      r = 32'hFFFFFFFF;
      for (int i = 64; i < obits.size(); i++) r = crc_bit(r, obits[i]);
      checks++;
      if (r !== 32'hC704DD7B) begin failures++; $display("FAIL residue frame=%0d got=%h exp=c704dd7b", f, r); end
    end
  endtask

  task automatic test_reset_mid_fcs();
    int gaps, tries, cycles, ready_hi, n, bad;
    clear_capture();
    send_frame(pay_basic, 0, gaps, tries);
    n = 0;
    while (obits.size() < 146 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sif.out_valid !== 1'b1 || obits.size() != 146) begin
      failures++;
      $display("FAIL midreset_reach_fcs10 out_valid=%b bits=%0d exp=1,146", sif.out_valid, obits.size());
    end
    reset = 1'b0;
    #1;
    checks++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b0 || sif.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_immediate out_valid=%b busy=%b in_ready=%b exp=000", sif.out_valid, busy, sif.in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (eof_cnt != 0 || abort_cnt != 0) begin
      failures++;
      $display("FAIL midreset_no_completion eof=%0d abort=%0d exp=0,0", eof_cnt, abort_cnt);
    end
    clear_capture();
    send_frame(pay_basic, 0, gaps, tries);
    wait_eof(1, cycles, ready_hi);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (136 + i >= obits.size() || obits[136 + i] !== fcs_basic[i]) bad++;
    end
    checks++;
    if (bad != 0 || fcs_value !== 32'h649C2FD3) begin
      failures++;
      $display("FAIL midreset_next_frame bad_fcs_bits=%0d fcs_value=%h exp=0,649c2fd3", bad, fcs_value);
    end
  endtask

`ifdef SERIAL_FCS_PAD_EN
  task automatic test_pad();
    logic [7:0]  bytes[$];
    logic        pay[$];
    logic [31:0] r;
    int          gaps, tries, cycles, ready_hi, ones;
    bytes = '{8'hA5, 8'h3C};
    bytes_to_bits(bytes, pay);
    clear_capture();
    send_frame(pay, 0, gaps, tries);
    wait_eof(1, cycles, ready_hi);
    checks++;
    if (obits.size() != 576 || cycles != 496) begin
      failures++;
      $display("FAIL pad_short_length bits=%0d cycles=%0d exp=576,496", obits.size(), cycles);
    end
    ones = 0;
    for (int i = 80; i < 544 && i < obits.size(); i++) if (obits[i] !== 1'b0) ones++;
    checks++;
    if (ones != 0) begin failures++; $display("FAIL pad_zero_bits nonzero=%0d exp=0", ones); end
    r = 32'hFFFFFFFF;
    for (int i = 64; i < obits.size(); i++) r = crc_bit(r, obits[i]);
    checks++;
    if (r !== 32'hC704DD7B) begin failures++; $display("FAIL pad_residue got=%h exp=c704dd7b", r); end

    bytes.delete();
    for (int k = 0; k < 60; k++) bytes.push_back(8'($urandom));
    bytes_to_bits(bytes, pay);
    clear_capture();
    send_frame(pay, 0, gaps, tries);
    wait_eof(1, cycles, ready_hi);
    checks++;
    if (obits.size() != 576 || cycles != 32) begin
      failures++;
      $display("FAIL pad_exact_no_pad bits=%0d cycles=%0d exp=576,32", obits.size(), cycles);
    end
    r = 32'hFFFFFFFF;
    for (int i = 64; i < obits.size(); i++) r = crc_bit(r, obits[i]);
    checks++;
    if (r !== 32'hC704DD7B) begin failures++; $display("FAIL pad_exact_residue got=%h exp=c704dd7b", r); end
  endtask
`endif

  initial begin
    logic [7:0] bq[$];
    logic       tmp[$];
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_data  = 1'b0;
    sif.in_sof   = 1'b0;
    sif.in_eof   = 1'b0;
    clear_capture();

    bq = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
    bytes_to_bits(bq, pre_bits);
    bq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    bytes_to_bits(bq, pay_basic);
    bq = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    bytes_to_bits(bq, fcs_basic);
    exp_basic.delete();
    foreach (pre_bits[i])  exp_basic.push_back(pre_bits[i]);
    foreach (pay_basic[i]) exp_basic.push_back(pay_basic[i]);
    foreach (fcs_basic[i]) exp_basic.push_back(fcs_basic[i]);
    tmp.delete();

    @(negedge clk);
    test_reset();
    test_basic();
    test_abort();
    test_gaps();
    test_back_to_back();
    test_residue();
    test_reset_mid_fcs();
`ifdef SERIAL_FCS_PAD_EN
    test_pad();
`endif
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
